cpu_step_controller: RTL and testbench

//   Sequencer for the CPU clock-enable on the Basys board. Generates a single-cycle
//   cpu_tick enable in sysclk domain for the ARM core in four modes: halted, free run
//   at a programmable divided rate, single step, and burst of N steps.

---
 rtl/cpu_step_controller.sv | 154 +++++++++++++++
 tb/tb_cpu_step_controller.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_controller.sv
// CPU clock-enable sequencer: halted, free run, single step and N-step burst modes,
// with a PC breakpoint that stops the core and a running count of issued ticks.
module cpu_step_controller #(
  parameter int DIV_WIDTH   = 24,
  parameter int DEFAULT_DIV = 1_000_000,
  parameter int BURST_WIDTH = 8,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   sysclk,
  input  logic                   rst_n,
  input  logic                   run_pulse,
  input  logic                   step_pulse,
  input  logic                   burst_pulse,
  input  logic                   halt_pulse,
  input  logic [BURST_WIDTH-1:0] burst_count,
  input  logic                   div_load,
  input  logic [DIV_WIDTH-1:0]   div_value,
  input  logic                   bp_enable,
  input  logic [ADDR_WIDTH-1:0]  bp_addr,
  input  logic [ADDR_WIDTH-1:0]  pc,
  output logic                   cpu_tick,
  output logic [1:0]             mode,
  output logic                   bp_hit,
  output logic [31:0]            tick_count
);

  localparam logic [1:0] MODE_HALT  = 2'b00;
  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b10;

  localparam logic [DIV_WIDTH-1:0]   DIV_ONE   = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0]   DIV_RESET = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [BURST_WIDTH-1:0] REM_ONE   = BURST_WIDTH'(1);

  logic [1:0]             mode_q, mode_d;
  logic                   cpu_tick_q, cpu_tick_d;
  logic                   bp_hit_q, bp_hit_d;
  logic [31:0]            tick_count_q, tick_count_d;
  logic [DIV_WIDTH-1:0]   divider_q, divider_d;
  logic [DIV_WIDTH-1:0]   period_q, period_d;
  logic [BURST_WIDTH-1:0] remaining_q, remaining_d;
  logic                   bp_armed_q, bp_armed_d;

  logic [DIV_WIDTH-1:0]   period_sel;
  logic [DIV_WIDTH-1:0]   last_count;
  logic [DIV_WIDTH-1:0]   divider_cur;
  logic                   tick_due;
  logic                   bp_match;

  // A new period loaded this edge restarts the divider and is used for this edge's compare.
  always_comb begin
    period_sel  = div_load ? div_value : period_q;
    last_count  = (period_sel == '0) ? '0 : period_sel - DIV_ONE;
    divider_cur = div_load ? '0 : divider_q;
    tick_due    = (divider_cur == last_count);
    bp_match    = bp_enable & bp_armed_q & (pc == bp_addr);

    mode_d      = mode_q;
    cpu_tick_d  = 1'b0;
    bp_hit_d    = bp_hit_q;
    divider_d   = divider_cur;
    period_d    = period_sel;
    remaining_d = remaining_q;
    bp_armed_d  = bp_armed_q;

    case (mode_q)
      MODE_HALT: begin
        if (halt_pulse) begin
          remaining_d = '0;
        end else if (step_pulse) begin
          cpu_tick_d = 1'b1;
          bp_hit_d   = 1'b0;
          bp_armed_d = 1'b0;
        end else if (burst_pulse && (burst_count != '0)) begin
          mode_d      = MODE_BURST;
          remaining_d = burst_count;
          divider_d   = '0;
          bp_hit_d    = 1'b0;
          bp_armed_d  = 1'b0;
        end else if (run_pulse) begin
          mode_d     = MODE_RUN;
          divider_d  = '0;
          bp_hit_d   = 1'b0;
          bp_armed_d = 1'b0;
        end
      end
      MODE_RUN, MODE_BURST: begin
        if (halt_pulse) begin
          mode_d      = MODE_HALT;
          remaining_d = '0;
        end else if (bp_match) begin
          mode_d      = MODE_HALT;
          bp_hit_d    = 1'b1;
          remaining_d = '0;
        end else begin
          if (run_pulse && (mode_q == MODE_BURST)) begin
            mode_d      = MODE_RUN;
            remaining_d = '0;
          end
          if (tick_due) begin
            cpu_tick_d = 1'b1;
            divider_d  = '0;
            bp_armed_d = 1'b1;
            // The tick that spends the last burst step also drops back to HALT.
            if ((mode_q == MODE_BURST) && !run_pulse) begin
              if (remaining_q <= REM_ONE) begin
                remaining_d = '0;
                mode_d      = MODE_HALT;
              end else begin
                remaining_d = remaining_q - REM_ONE;
              end
            end
          end else begin
            divider_d = divider_cur + DIV_ONE;
          end
        end
      end
      default: begin
        mode_d      = MODE_HALT;
        remaining_d = '0;
      end
    endcase

    tick_count_d = tick_count_q + 32'(cpu_tick_d);
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= MODE_HALT;
      cpu_tick_q   <= 1'b0;
      bp_hit_q     <= 1'b0;
      tick_count_q <= '0;
      divider_q    <= '0;
      period_q     <= DIV_RESET;
      remaining_q  <= '0;
      bp_armed_q   <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      cpu_tick_q   <= cpu_tick_d;
      bp_hit_q     <= bp_hit_d;
      tick_count_q <= tick_count_d;
      divider_q    <= divider_d;
      period_q     <= period_d;
      remaining_q  <= remaining_d;
      bp_armed_q   <= bp_armed_d;
    end
  end

  assign cpu_tick   = cpu_tick_q;
  assign mode       = mode_q;
  assign bp_hit     = bp_hit_q;
  assign tick_count = tick_count_q;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Directed bench for cpu_step_controller: step, burst, breakpoint run-off, halt
// suppression, zero burst, tick counter wrap and asynchronous reset mid-burst.
module tb_cpu_step_controller;

  localparam logic [1:0] M_HALT  = 2'b00;
  localparam logic [1:0] M_RUN   = 2'b01;
  localparam logic [1:0] M_BURST = 2'b10;

  logic        sysclk;
  logic        rst_n;
  logic        run_pulse;
  logic        step_pulse;
  logic        burst_pulse;
  logic        halt_pulse;
  logic [7:0]  burst_count;
  logic        div_load;
  logic [23:0] div_value;
  logic        bp_enable;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic        cpu_tick;
  logic [1:0]  mode;
  logic        bp_hit;
  logic [31:0] tick_count;

  int          vectors;
  int          miscompares;
  logic [31:0] exp_count;

  cpu_step_controller dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .run_pulse   (run_pulse),
    .step_pulse  (step_pulse),
    .burst_pulse (burst_pulse),
    .halt_pulse  (halt_pulse),
    .burst_count (burst_count),
    .div_load    (div_load),
    .div_value   (div_value),
    .bp_enable   (bp_enable),
    .bp_addr     (bp_addr),
    .pc          (pc),
    .cpu_tick    (cpu_tick),
    .mode        (mode),
    .bp_hit      (bp_hit),
    .tick_count  (tick_count)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock: inputs change and outputs are sampled on the falling edge.
  task automatic cycle();
    @(posedge sysclk);
    @(negedge sysclk);
  endtask

  task automatic load_period(input logic [23:0] value);
    div_value = value;
    div_load  = 1'b1;
    cycle();
    div_load  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    vectors++;
    if (mode !== M_HALT || cpu_tick !== 1'b0 || bp_hit !== 1'b0 || tick_count !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got mode=%b tick=%b bp_hit=%b count=%0d expected 00/0/0/0",
               mode, cpu_tick, bp_hit, tick_count);
    end
    exp_count = 32'd0;
  endtask

  task automatic test_step();
    step_pulse = 1'b1;
    cycle();
    step_pulse = 1'b0;
    exp_count  = exp_count + 32'd1;
    vectors++;
    if (cpu_tick !== 1'b1 || tick_count !== exp_count || mode !== M_HALT) begin
      miscompares++;
      $display("[TB] FAIL step_tick: got tick=%b count=%0d mode=%b expected 1/%0d/00",
               cpu_tick, tick_count, mode, exp_count);
    end
    cycle();
    vectors++;
    if (cpu_tick !== 1'b0 || tick_count !== exp_count) begin
      miscompares++;
      $display("[TB] FAIL step_single: got tick=%b count=%0d expected 0/%0d",
               cpu_tick, tick_count, exp_count);
    end
  endtask

  task automatic test_burst();
    load_period(24'd4);
    burst_count = 8'd3;
    burst_pulse = 1'b1;
    cycle();
    burst_pulse = 1'b0;
    vectors++;
    if (mode !== M_BURST) begin
      miscompares++;
      $display("[TB] FAIL burst_entry: got mode=%b expected 10", mode);
    end
    for (int k = 1; k <= 16; k++) begin
      logic exp_tick;
      logic [1:0] exp_mode;
      cycle();
      exp_tick = (k <= 12) && (k % 4 == 0);
      exp_mode = (k < 12) ? M_BURST : M_HALT;
      if (exp_tick) exp_count = exp_count + 32'd1;
      vectors++;
      if (cpu_tick !== exp_tick || mode !== exp_mode || tick_count !== exp_count) begin
        miscompares++;
        $display("[TB] FAIL burst_cycle%0d: got tick=%b mode=%b count=%0d expected %b/%b/%0d",
                 k, cpu_tick, mode, tick_count, exp_tick, exp_mode, exp_count);
      end
    end
  endtask

  task automatic test_breakpoint();
    load_period(24'd2);
    bp_addr   = 32'h0000_0100;
    bp_enable = 1'b1;
    pc        = 32'h0000_0000;
    run_pulse = 1'b1;
    cycle();
    run_pulse = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      logic exp_tick;
      cycle();
      exp_tick = (k % 2 == 0);
      if (exp_tick) exp_count = exp_count + 32'd1;
      vectors++;
      if (cpu_tick !== exp_tick || mode !== M_RUN) begin
        miscompares++;
        $display("[TB] FAIL bp_run%0d: got tick=%b mode=%b expected %b/01", k, cpu_tick, mode, exp_tick);
      end
    end
    pc = 32'h0000_0100;
    for (int k = 0; k < 5; k++) begin
      cycle();
      vectors++;
      if (cpu_tick !== 1'b0 || mode !== M_HALT || bp_hit !== 1'b1 || tick_count !== exp_count) begin
        miscompares++;
        $display("[TB] FAIL bp_halt%0d: got tick=%b mode=%b bp_hit=%b count=%0d expected 0/00/1/%0d",
                 k, cpu_tick, mode, bp_hit, tick_count, exp_count);
      end
    end
    // Resume with pc still on the breakpoint: the first tick must get through.
    run_pulse = 1'b1;
    cycle();
    run_pulse = 1'b0;
    vectors++;
    if (mode !== M_RUN || bp_hit !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bp_resume: got mode=%b bp_hit=%b expected 01/0", mode, bp_hit);
    end
    for (int k = 1; k <= 6; k++) begin
      logic exp_tick;
      cycle();
      exp_tick = (k % 2 == 0);
      if (exp_tick) exp_count = exp_count + 32'd1;
      vectors++;
      if (cpu_tick !== exp_tick || mode !== M_RUN) begin
        miscompares++;
        $display("[TB] FAIL bp_runoff%0d: got tick=%b mode=%b expected %b/01", k, cpu_tick, mode, exp_tick);
      end
      if (k == 2) pc = 32'h0000_0104;
    end
    pc = 32'h0000_0100;
    cycle();
    vectors++;
    if (cpu_tick !== 1'b0 || mode !== M_HALT || bp_hit !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL bp_rehit: got tick=%b mode=%b bp_hit=%b expected 0/00/1", cpu_tick, mode, bp_hit);
    end
    bp_enable = 1'b0;
    pc        = 32'h0000_0000;
  endtask

  task automatic test_halt_on_tick();
    run_pulse = 1'b1;
    cycle();
    run_pulse = 1'b0;
    cycle();
    halt_pulse = 1'b1;
    cycle();
    halt_pulse = 1'b0;
    vectors++;
    if (cpu_tick !== 1'b0 || mode !== M_HALT || bp_hit !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL halt_due_tick: got tick=%b mode=%b bp_hit=%b expected 0/00/0", cpu_tick, mode, bp_hit);
    end
    for (int k = 0; k < 3; k++) begin
      cycle();
      vectors++;
      if (cpu_tick !== 1'b0 || tick_count !== exp_count) begin
        miscompares++;
        $display("[TB] FAIL halt_quiet%0d: got tick=%b count=%0d expected 0/%0d", k, cpu_tick, tick_count, exp_count);
      end
    end
    halt_pulse = 1'b1;
    step_pulse = 1'b1;
    cycle();
    halt_pulse = 1'b0;
    step_pulse = 1'b0;
    vectors++;
    if (cpu_tick !== 1'b0 || mode !== M_HALT || tick_count !== exp_count) begin
      miscompares++;
      $display("[TB] FAIL halt_plus_step: got tick=%b mode=%b count=%0d expected 0/00/%0d",
               cpu_tick, mode, tick_count, exp_count);
    end
  endtask

  task automatic test_burst_to_run();
    burst_count = 8'd1;
    burst_pulse = 1'b1;
    cycle();
    burst_pulse = 1'b0;
    cycle();
    run_pulse = 1'b1;
    cycle();
    run_pulse = 1'b0;
    exp_count = exp_count + 32'd1;
    vectors++;
    if (cpu_tick !== 1'b1 || mode !== M_RUN) begin
      miscompares++;
      $display("[TB] FAIL burst_to_run: got tick=%b mode=%b expected 1/01", cpu_tick, mode);
    end
    cycle();
    cycle();
    exp_count = exp_count + 32'd1;
    vectors++;
    if (cpu_tick !== 1'b1 || mode !== M_RUN || tick_count !== exp_count) begin
      miscompares++;
      $display("[TB] FAIL run_after_burst: got tick=%b mode=%b count=%0d expected 1/01/%0d",
               cpu_tick, mode, tick_count, exp_count);
    end
    halt_pulse = 1'b1;
    cycle();
    halt_pulse = 1'b0;
  endtask

  task automatic test_burst_zero();
    burst_count = 8'd0;
    burst_pulse = 1'b1;
    cycle();
    burst_pulse = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (cpu_tick !== 1'b0 || mode !== M_HALT || tick_count !== exp_count) begin
        miscompares++;
        $display("[TB] FAIL burst_zero%0d: got tick=%b mode=%b count=%0d expected 0/00/%0d",
                 k, cpu_tick, mode, tick_count, exp_count);
      end
      cycle();
    end
  endtask

  task automatic test_wrap();
    force dut.tick_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.tick_count_q;
    step_pulse = 1'b1;
    cycle();
    step_pulse = 1'b0;
    exp_count = 32'd0;
    vectors++;
    if (cpu_tick !== 1'b1 || tick_count !== exp_count) begin
      miscompares++;
      $display("[TB] FAIL count_wrap: got tick=%b count=%h expected 1/%h", cpu_tick, tick_count, exp_count);
    end
  endtask

  task automatic test_reset_mid_burst();
    burst_count = 8'd8;
    burst_pulse = 1'b1;
    cycle();
    burst_pulse = 1'b0;
    for (int k = 1; k <= 6; k++) cycle();
    vectors++;
    if (cpu_tick !== 1'b1 || mode !== M_BURST) begin
      miscompares++;
      $display("[TB] FAIL pre_reset: got tick=%b mode=%b expected 1/10", cpu_tick, mode);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (cpu_tick !== 1'b0 || mode !== M_HALT || bp_hit !== 1'b0 || tick_count !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got tick=%b mode=%b bp_hit=%b count=%0d expected 0/00/0/0",
               cpu_tick, mode, bp_hit, tick_count);
    end
    @(negedge sysclk);
    cycle();
    rst_n     = 1'b1;
    exp_count = 32'd0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      vectors++;
      if (cpu_tick !== 1'b0 || mode !== M_HALT || tick_count !== exp_count) begin
        miscompares++;
        $display("[TB] FAIL post_reset%0d: got tick=%b mode=%b count=%0d expected 0/00/0",
                 k, cpu_tick, mode, tick_count);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_count   = 32'd0;
    rst_n       = 1'b0;
    run_pulse   = 1'b0;
    step_pulse  = 1'b0;
    burst_pulse = 1'b0;
    halt_pulse  = 1'b0;
    burst_count = 8'd0;
    div_load    = 1'b0;
    div_value   = 24'd0;
    bp_enable   = 1'b0;
    bp_addr     = 32'd0;
    pc          = 32'd0;
    @(negedge sysclk);

    $display("[TB] starting cpu_step_controller directed tests");
    test_reset();
    test_step();
    test_burst();
    test_breakpoint();
    test_halt_on_tick();
    test_burst_to_run();
    test_burst_zero();
    test_wrap();
    test_reset_mid_burst();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
